booth_dot_accumulator: RTL
==========================

// Module: booth_dot_accumulator
// PURPOSE
//   Downstream consumer of the 16x16 radix-4 Booth multiplier (mbm). Accumulates a run of LEN signed
//   32-bit products into a saturating ACC_W-bit sum (dot product / FIR tap sum).
//   Uses valid/ready handshakes on both the product input and the result output.
//   The multiplier stays combinational; this block supplies the registered, sequential back end.
// PARAMETERS
//   PROD_W  32  width of incoming signed product (matches mbm product)
//   ACC_W   40  accumulator width; must satisfy ACC_W >= PROD_W
//   LEN_W   8   width of run-length field; max run = 2**LEN_W-1 products
// PORTS
//   clk          in   1       single clock; all state updates on rising edge
//   rst          in   1       reset, synchronous, active-high
//   start        in   1       begin a run; sampled only in IDLE
//   len          in   LEN_W   number of products in the run; sampled with start
//   busy         out  1       high in ACCUM and HOLD
//   in_valid     in   1       in_product is valid
//   in_ready     out  1       block accepts a product this cycle
//   in_product   in   PROD_W  signed product from mbm
//   out_valid    out  1       result available
//   out_ready    in   1       downstream accepts the result
//   out_acc      out  ACC_W   signed accumulated result
//   out_sat      out  1       sticky flag: at least one accumulate in this run saturated
// BEHAVIOUR
//   Reset: state=IDLE; acc=0; count=0; out_sat=0; in_ready=0; out_valid=0; busy=0.
//   rst overrides everything, including mid-run and mid-HOLD. No partial result survives reset.
//   FSM states:
//     IDLE -> ACCUM when start && len!=0. On that edge: acc<=0, out_sat<=0, count<=len.
//     IDLE -> HOLD  when start && len==0. On that edge: acc<=0, out_sat<=0 (empty run, result 0).
//     ACCUM -> HOLD when a beat is accepted while count==1.
//     HOLD  -> IDLE when out_valid && out_ready.
//   start outside IDLE is ignored; len is not re-sampled.
//   in_ready = (state==ACCUM). It is combinational from state only and never depends on in_valid.
//   A beat is accepted when in_valid && in_ready. On acceptance:
//     - count<=count-1.
//     - acc<=sat(acc + sign_extend(in_product, ACC_W)).
//   Saturation:
//     - Compute the sum at ACC_W+1 bits.
//     - On positive overflow, clamp to 2**(ACC_W-1)-1. On negative overflow, clamp to -2**(ACC_W-1).
//     - Any clamp sets out_sat, which stays set until the next run starts.
//     - Accumulation continues from the clamped value.
//   In ACCUM, cycles with in_valid=0 do not change state. There is no timeout.
//   out_valid = (state==HOLD). out_acc and out_sat are registered and stay stable while out_valid=1.
//   Latency:
//     - The result is visible on the cycle after the last beat is accepted.
//     - Throughput is one product per cycle.
//     - With out_ready tied high: one extra HOLD cycle, then IDLE. A new start is accepted on the following cycle.
//   out_acc is undefined (but deterministic) while out_valid=0. Benches compare it only when out_valid=1.
//   Simultaneous start and out_ready in HOLD: the block returns to IDLE, and that start is ignored.
//   All arithmetic is signed two's complement. No rounding or truncation.
// TESTING
//   1 len=4; products 6, -2, 100, -4 back to back -> out_valid 1 cycle after 4th accept; out_acc=100; out_sat=0.
//   2 len=3; in_valid gaps of 0/2/5 cycles between beats; out_ready low 3 cycles in HOLD ->
//     out_acc=-30 for products -10 x3; out_acc stable while stalled; in_ready=0 throughout HOLD.
//   3 ACC_W=34; len=10; each product 0x40000000 (=2**30) ->
//     clamps at 8th beat; out_acc=0x1_FFFF_FFFF; out_sat=1.
//     Next run len=1 with product 5 -> out_acc=5; out_sat=0.
//   4 ACC_W=34; len=9; each product 0xC0000000 (=-2**30) -> out_acc=-2**33; out_sat=1.
//   5 start with len=0 -> HOLD next cycle, out_acc=0, no beat accepted.
//     start asserted during ACCUM -> ignored; count unchanged.
//   6 rst for 1 cycle after 2 of 5 beats ->
//     IDLE; all outputs at reset values. A fresh len=2 run of 7, 8 -> out_acc=15.

Source files
------------

// File: rtl/booth_dot_accumulator.sv
// Saturating dot-product accumulator for signed products from the radix-4 Booth multiplier.
// Sums a run of LEN products into an ACC_W-bit result, with valid/ready handshakes on input and output.
module booth_dot_accumulator #(
  parameter int unsigned PROD_W = 32,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_len,
  output logic                    o_busy,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [PROD_W-1:0]       i_in_product,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [ACC_W-1:0]        o_out_acc,
  output logic                    o_out_sat
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned EXT_W = SUM_W - PROD_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_busy;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                w_busy_nxt;
  logic                w_in_ready_nxt;
  logic                w_out_valid_nxt;

  logic [LEN_W-1:0]    r_count;
  logic [ACC_W-1:0]    r_acc;
  logic                r_sat;

  logic                w_accept;
  logic                w_start_run;
  logic [SUM_W-1:0]    w_prod_ext;
  logic [SUM_W-1:0]    w_acc_ext;
  logic [SUM_W-1:0]    w_sum;
  logic                w_ovf;
  logic [ACC_W-1:0]    w_acc_sat;

  assign w_accept    = i_in_valid && (r_state == S_ACCUM);
  assign w_start_run = i_start && (r_state == S_IDLE);

  // State register; handshake/status outputs are registered from the next-state decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state logic; start outside IDLE (including HOLD) is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_len != '0) ? S_ACCUM : S_HOLD;
        end
      end
      S_ACCUM: begin
        if (w_accept && (r_count == LEN_W'(1))) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state.
  always_comb begin
    w_busy_nxt      = 1'b0;
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_ACCUM: begin
        w_busy_nxt     = 1'b1;
        w_in_ready_nxt = 1'b1;
      end
      S_HOLD: begin
        w_busy_nxt      = 1'b1;
        w_out_valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // One guard bit is enough: a disagreement between the top two sum bits marks overflow.
  assign w_prod_ext = {{EXT_W{i_in_product[PROD_W-1]}}, i_in_product};
  assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
  assign w_sum      = w_acc_ext + w_prod_ext;
  assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_sat  = !w_ovf        ? w_sum[ACC_W-1:0] :
                      w_sum[ACC_W]  ? ACC_MIN          : ACC_MAX;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_start_run) begin
      r_acc   <= '0;
      r_count <= i_len;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_sat;
      r_count <= r_count - LEN_W'(1);
      if (w_ovf) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_acc   = r_acc;
  assign o_out_sat   = r_sat;

endmodule
